alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/result width (even, >= 8).
REQ-002 SHALL have port clk_i, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port valid_i, input, 1: request valid.
REQ-005 SHALL have port ready_o, output, 1: unit can accept a request.
REQ-006 SHALL have port op_i, input, 3: RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 SHALL have ports operand_a_i and operand_b_i, input, DATA_WIDTH: rs1 and rs2 data.
REQ-008 SHALL have port kill_i, input, 1: pipeline flush, abandons any operation.
REQ-009 SHALL have port result_o, output, DATA_WIDTH: registered result.
REQ-010 SHALL have port valid_o, output, 1: result_o valid.
REQ-011 SHALL have port ready_i, input, 1: consumer accepts the result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIXUP, DONE; ready_o = (state==IDLE) && !rst_i; valid_o = (state==DONE).
REQ-013 SHALL accept a request on an edge with valid_i && ready_o && !kill_i, latching op, operands, operand signs and magnitudes.
REQ-014 SHALL run exactly DATA_WIDTH iterations in CALC (one bit per cycle, counter 0..DATA_WIDTH-1), then one FIXUP cycle, then DONE; valid_o rises DATA_WIDTH+2 edges after the accepting edge (34 for 32 bits).
REQ-015 SHALL multiply by unsigned shift-add of magnitudes into a 2*DATA_WIDTH product; FIXUP negates the product when the operand signs differ (signedness per op: MULH both signed, MULHSU a only, MULHU/MUL neither for sign purposes of low half).
REQ-016 SHALL return the low DATA_WIDTH bits for MUL and the high DATA_WIDTH bits for MULH/MULHSU/MULHU.
REQ-017 SHALL divide by restoring division of magnitudes; FIXUP negates the quotient when signs differ (DIV) and the remainder when the dividend is negative (REM); results truncate toward zero.
REQ-018 SHALL, on divide by zero, skip CALC and enter DONE on the accepting edge, with quotient all ones and remainder = operand_a_i.
REQ-019 SHALL, on signed overflow (DIV/REM, a = most-negative, b = -1), enter DONE on the accepting edge, with quotient = a and remainder = 0.
REQ-020 SHALL hold result_o and valid_o stable in DONE until ready_i is high on an edge, then return to IDLE; back-to-back acceptance of the next request is not permitted in that same cycle.
REQ-021 SHALL, on kill_i high in any state, return to IDLE on that edge with valid_o low; kill_i takes priority over valid_i and ready_i.
REQ-022 SHALL ignore op_i and operand changes after acceptance.

Reset
REQ-023 SHALL, on an edge with rst_i high, set state IDLE, counter 0, result_o 0, valid_o 0, and all datapath registers 0; reset has priority over kill_i and handshakes.
REQ-024 SHALL drive ready_o low while rst_i is high and high on the first cycle after reset release.

Structure
REQ-025 SHALL take the op_i encodings and FSM state encodings from shared package alu_pkg, which also holds the existing ALU control codes.
REQ-026 SHALL place the single-bit restoring-division step (compare, conditional subtract, shift) in sub-module div_step; the multiplier step stays inline.

Verification
REQ-027 SHALL cover MUL 7 x 0xFFFFFFFD -> result_o 0xFFFFFFEB, with valid_o high exactly 34 cycles after acceptance.
REQ-028 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000, MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE, and MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-029 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, REM same operands -> 0xFFFFFFFF, and DIVU 100 / 7 -> 14.
REQ-030 SHALL cover DIVU 5 / 0 -> 0xFFFFFFFF, REMU 5 / 0 -> 5, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM same operands -> 0, each with valid_o on the edge after acceptance.
REQ-031 SHALL cover ready_i held low 10 cycles in DONE -> result_o/valid_o stable, ready_o low, and a concurrent valid_i request not accepted.
REQ-032 SHALL cover kill_i (then separately rst_i) asserted on CALC iteration 10 -> IDLE next edge, valid_o never rises, and a following MUL 3 x 4 -> 12 is correct.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: legacy ALU control codes, RV32M funct3 codes and
// the multiply/divide unit FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // MUL treats both operands as unsigned: its low half is sign-agnostic.
    function automatic logic md_a_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_b_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module div_step
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);

    logic [DATA_WIDTH:0] w_shift;
    logic [DATA_WIDTH:0] w_diff;
    logic                w_ge;

    assign w_shift = {rem_i, quo_i[DATA_WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, divisor_i};
    assign w_ge    = (w_shift >= {1'b0, divisor_i});
    assign rem_o   = w_ge ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
    assign quo_o   = {quo_i[DATA_WIDTH-2:0], w_ge};

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand
// magnitudes, then a single sign-fixup cycle before presenting the result.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    input  logic                  kill_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [W-1:0]     r_mag_a;
    logic [W-1:0]     r_mag_b;
    logic [2*W-1:0]   r_acc;
    logic [W-1:0]     r_result;

    logic             w_accept;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [W-1:0]     w_mag_a;
    logic [W-1:0]     w_mag_b;
    logic             w_div0;
    logic             w_ovf;
    logic [W:0]       w_mul_sum;
    logic [2*W-1:0]   w_mul_next;
    logic [W-1:0]     w_rem_next;
    logic [W-1:0]     w_quo_next;
    logic [2*W-1:0]   w_prod_fix;
    logic [W-1:0]     w_quo;
    logic [W-1:0]     w_rem;
    logic [W-1:0]     w_quo_fix;
    logic [W-1:0]     w_rem_fix;
    logic [W-1:0]     w_fix_result;

    assign ready_o  = (r_state == ST_IDLE) && !rst_i;
    assign valid_o  = (r_state == ST_DONE);
    assign result_o = r_result;
    assign w_accept = valid_i && ready_o && !kill_i;

    assign w_sign_a = md_a_signed(op_i) && operand_a_i[W-1];
    assign w_sign_b = md_b_signed(op_i) && operand_b_i[W-1];
    assign w_mag_a  = w_sign_a ? -operand_a_i : operand_a_i;
    assign w_mag_b  = w_sign_b ? -operand_b_i : operand_b_i;
    assign w_div0   = op_i[2] && (operand_b_i == '0);
    assign w_ovf    = op_i[2] && !op_i[0] && (operand_a_i == {1'b1, {(W-1){1'b0}}})
                      && (operand_b_i == '1);

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_mag_a} : {(W+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    div_step #(.DATA_WIDTH(W)) u_div_step (
        .rem_i     (r_acc[2*W-1:W]),
        .quo_i     (r_acc[W-1:0]),
        .divisor_i (r_mag_b),
        .rem_o     (w_rem_next),
        .quo_o     (w_quo_next)
    );

    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quo      = r_acc[W-1:0];
    assign w_rem      = r_acc[2*W-1:W];
    assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? -w_quo : w_quo;
    assign w_rem_fix  = r_sign_a ? -w_rem : w_rem;

    always_comb begin
        w_fix_result = '0;
        if (!r_op[2]) begin
            w_fix_result = (r_op[1:0] == 2'b00) ? w_prod_fix[W-1:0] : w_prod_fix[2*W-1:W];
        end else begin
            w_fix_result = r_op[1] ? w_rem_fix : w_quo_fix;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (kill_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op     <= op_i;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_mag_a  <= w_mag_a;
                        r_mag_b  <= w_mag_b;
                        r_cnt    <= '0;
                        // Degenerate divides resolve immediately without iterating.
                        if (w_div0) begin
                            r_result <= op_i[1] ? operand_a_i : '1;
                            r_state  <= ST_DONE;
                        end else if (w_ovf) begin
                            r_result <= op_i[1] ? '0 : operand_a_i;
                            r_state  <= ST_DONE;
                        end else begin
                            r_acc   <= {{W{1'b0}}, op_i[2] ? w_mag_a : w_mag_b};
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc <= r_op[2] ? {w_rem_next, w_quo_next} : w_mul_next;
                    if (r_cnt == CNT_W'(W-1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_FIXUP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FIXUP: begin
                    r_result <= w_fix_result;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: a driver queues expected results from a
// plain-arithmetic RV32M model, a monitor checks each result as it appears.
module tb_alu_muldiv;

    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [2:0]    op_i;
    logic [DW-1:0] operand_a_i;
    logic [DW-1:0] operand_b_i;
    logic          kill_i;
    logic [DW-1:0] result_o;
    logic          valid_o;
    logic          ready_i;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
        logic [2:0]  op;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_v;

    alu_muldiv #(.DATA_WIDTH(DW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .op_i        (op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .kill_i      (kill_i),
        .result_o    (result_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d", sb_q.size());
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = sa / sb; return q[31:0];
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DW + 2;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input logic track);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk_i);
        while (ready_o !== 1'b1 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (ready_o !== 1'b1) begin
            chk("ready_timeout", {31'b0, ready_o}, 32'h1);
            return;
        end
        valid_i     = 1'b1;
        op_i        = op;
        operand_a_i = a;
        operand_b_i = b;
        @(posedge clk_i);
        #1;
        if (track) begin
            e.res = exp;
            e.lat = lat;
            e.acc = cyc;
            e.op  = op;
            sb_q.push_back(e);
        end
        valid_i     = 1'b0;
        op_i        = 3'($urandom);
        operand_a_i = $urandom;
        operand_b_i = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || valid_o === 1'b1) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_pending", 32'(sb_q.size()), 32'h0);
    endtask

    // Monitor: every rising valid_o must match the oldest outstanding request.
    always @(negedge clk_i) begin
        if (valid_o === 1'b1 && prev_v !== 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got result %h, expected no result", result_o);
            end else begin
                mon_e = sb_q.pop_front();
                chk($sformatf("result_op%0d", mon_e.op), result_o, mon_e.res);
                chk($sformatf("latency_op%0d", mon_e.op), 32'(cyc + 1 - mon_e.acc), 32'(mon_e.lat));
            end
        end
        prev_v = valid_o;
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          n;

        rst_i       = 1'b1;
        valid_i     = 1'b0;
        kill_i      = 1'b0;
        ready_i     = 1'b1;
        op_i        = 3'b000;
        operand_a_i = '0;
        operand_b_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("ready_in_reset", {31'b0, ready_o}, 32'h0);
        @(posedge clk_i);
        #1;
        chk("reset_result", result_o, 32'h0);
        chk("reset_valid", {31'b0, valid_o}, 32'h0);
        rst_i = 1'b0;
        #1;
        chk("ready_after_reset", {31'b0, ready_o}, 32'h1);

        issue(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b1);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b1);
        issue(3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, 1'b1);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 1'b1);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 1'b1);
        issue(3'b101, 32'd100,       32'd7,         32'd14,        34, 1'b1);
        issue(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1'b1);
        issue(3'b111, 32'd5,         32'd0,         32'd5,         1,  1'b1);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b1);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1,  1'b1);
        drain();

        // Consumer stall: result held, new requests refused.
        ready_i = 1'b0;
        issue(3'b000, 32'd5, 32'd6, 32'd30, 34, 1'b1);
        n = 0;
        @(negedge clk_i);
        while (valid_o !== 1'b1 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("stall_valid_seen", {31'b0, valid_o}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            valid_i     = 1'b1;
            op_i        = 3'b101;
            operand_a_i = $urandom;
            operand_b_i = $urandom;
            chk($sformatf("stall_result_%0d", i), result_o, 32'd30);
            chk($sformatf("stall_valid_%0d", i), {31'b0, valid_o}, 32'h1);
            chk($sformatf("stall_ready_%0d", i), {31'b0, ready_o}, 32'h0);
            @(negedge clk_i);
        end
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        chk("stall_release_ready", {31'b0, ready_o}, 32'h1);
        chk("stall_release_valid", {31'b0, valid_o}, 32'h0);
        repeat (40) @(negedge clk_i);
        chk("stall_no_extra", {31'b0, valid_o}, 32'h0);

        // Flush during CALC iteration 10.
        issue(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 0, 1'b0);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        chk("kill_ready", {31'b0, ready_o}, 32'h1);
        chk("kill_valid", {31'b0, valid_o}, 32'h0);
        repeat (40) @(negedge clk_i);
        chk("kill_no_valid", {31'b0, valid_o}, 32'h0);
        issue(3'b000, 32'd3, 32'd4, 32'd12, 34, 1'b1);
        drain();

        // Reset during CALC iteration 10.
        issue(3'b100, 32'hDEAD_BEEF, 32'd3, 32'h0, 0, 1'b0);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_mid_ready", {31'b0, ready_o}, 32'h0);
        chk("rst_mid_result", result_o, 32'h0);
        chk("rst_mid_valid", {31'b0, valid_o}, 32'h0);
        rst_i = 1'b0;
        #1;
        chk("rst_mid_release", {31'b0, ready_o}, 32'h1);
        repeat (40) @(negedge clk_i);
        chk("rst_no_valid", {31'b0, valid_o}, 32'h0);
        issue(3'b000, 32'd3, 32'd4, 32'd12, 34, 1'b1);
        drain();

        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom);
            ra  = rnd_operand();
            rb  = rnd_operand();
            issue(rop, ra, rb, ref_model(rop, ra, rb), ref_lat(rop, ra, rb), 1'b1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
